// File: rtl/display_frame_fetcher_if.sv
// Frame-buffer read port and display FIFO write port of the frame fetcher.
// master = fetcher side, slave = memory/FIFO side.
interface display_frame_fetcher_if #(
  parameter int ADDR_WIDTH = 20
);
  logic                  o_mem_rd_en;
  logic [ADDR_WIDTH-1:0] o_mem_rd_addr;
  logic [11:0]           i_mem_rd_data;
  logic                  i_mem_rd_valid;
  logic                  o_wr;
  logic [11:0]           o_wdata;
  logic                  i_full;
  logic                  i_almost_full;

  modport master (
    output o_mem_rd_en,
    output o_mem_rd_addr,
    input  i_mem_rd_data,
    input  i_mem_rd_valid,
    output o_wr,
    output o_wdata,
    input  i_full,
    input  i_almost_full
  );

  modport slave (
    input  o_mem_rd_en,
    input  o_mem_rd_addr,
    output i_mem_rd_data,
    output i_mem_rd_valid,
    input  o_wr,
    input  o_wdata,
    output i_full,
    output i_almost_full
  );
endinterface

// File: rtl/display_frame_fetcher.sv
// Streams one RGB444 frame from a double-buffered frame store
// into the display pixel FIFO, honouring FIFO back-pressure.
module display_frame_fetcher #(
  parameter int FRAME_PIXELS = 307200,
  parameter int ADDR_WIDTH   = 20,
  parameter int RD_LATENCY   = 2
) (
  input  logic i_p_clk,
  input  logic i_rstn,
  input  logic i_req,
  input  logic i_buf_sel,
  display_frame_fetcher_if.master bus,
  output logic o_busy,
  output logic o_done,
  output logic o_overflow,
  output logic o_req_err
);
  localparam int IFW = $clog2(RD_LATENCY + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] LAST_PIX =
    ADDR_WIDTH'(FRAME_PIXELS - 1);
  localparam logic [ADDR_WIDTH-1:0] BUF1_BASE =
    ADDR_WIDTH'(FRAME_PIXELS);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] pix_q, pix_d;
  logic [IFW-1:0]        infl_q, infl_d;
  logic                  wr_q, wr_d;
  logic [11:0]           wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;
  logic                  rerr_q, rerr_d;

  logic issue;
  logic ret;

  // Gated by reset so an aborting cycle launches no orphan read.
  assign issue = i_rstn && (state_q == S_FETCH)
              && !bus.i_almost_full;
  // Returns with nothing outstanding are stale and ignored.
  assign ret = bus.i_mem_rd_valid && (infl_q != '0);

  assign bus.o_mem_rd_en   = issue;
  assign bus.o_mem_rd_addr = (state_q == S_FETCH)
                           ? base_q + pix_q : '0;
  assign bus.o_wr          = wr_q && !bus.i_full;
  assign bus.o_wdata       = wdata_q;

  assign o_busy     = (state_q != S_IDLE);
  assign o_done     = done_q;
  assign o_overflow = ovf_q;
  assign o_req_err  = rerr_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    pix_d   = pix_q;
    infl_d  = infl_q + IFW'(issue) - IFW'(ret);
    wr_d    = ret;
    wdata_d = ret ? bus.i_mem_rd_data : wdata_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q | (wr_q & bus.i_full);
    rerr_d  = rerr_q;
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (i_req) begin
          base_d  = i_buf_sel ? BUF1_BASE : '0;
          pix_d   = '0;
          state_d = S_FETCH;
        end
      end
      state_q == S_FETCH: begin
        if (i_req) rerr_d = 1'b1;
        if (issue) begin
          pix_d = pix_q + 1'b1;
          if (pix_q == LAST_PIX) state_d = S_DRAIN;
        end
      end
      state_q == S_DRAIN: begin
        if (i_req) rerr_d = 1'b1;
        // Last return already registered; its write is this cycle.
        if (infl_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_p_clk) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      pix_q   <= '0;
      infl_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      pix_q   <= pix_d;
      infl_q  <= infl_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      rerr_q  <= rerr_d;
    end
  end
endmodule

// File: tb/tb_display_frame_fetcher.sv
// Directed bench for display_frame_fetcher with a fixed-latency
// memory model and an in-order pixel scoreboard.
module tb_display_frame_fetcher;
  localparam int FP  = 2000;
  localparam int AW  = 12;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rstn;
  logic req;
  logic buf_sel;
  logic busy, done, ovf, rerr;

  always #5 clk = ~clk;

  display_frame_fetcher_if #(.ADDR_WIDTH(AW)) bus ();

  display_frame_fetcher #(
    .FRAME_PIXELS(FP),
    .ADDR_WIDTH  (AW),
    .RD_LATENCY  (LAT)
  ) dut (
    .i_p_clk   (clk),
    .i_rstn    (rstn),
    .i_req     (req),
    .i_buf_sel (buf_sel),
    .bus       (bus),
    .o_busy    (busy),
    .o_done    (done),
    .o_overflow(ovf),
    .o_req_err (rerr)
  );

  logic          pv [LAT];
  logic [AW-1:0] pa [LAT];
  logic          pl [LAT];
  logic          wr_due;

  // Memory: fixed latency, returns data = addr; pl marks live reads.
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
      pl[i] <= pl[i-1] & rstn;
    end
    pv[0]  <= bus.o_mem_rd_en;
    pa[0]  <= bus.o_mem_rd_addr;
    pl[0]  <= rstn;
    wr_due <= rstn & pv[LAT-1] & pl[LAT-1];
  end

  assign bus.i_mem_rd_valid = pv[LAT-1];
  assign bus.i_mem_rd_data  = pa[LAT-1][11:0];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int t0;
  int exp_addr, issue_cnt, wr_cnt, drop_cnt, done_cnt;
  int first_wr_cyc, last_wr_cyc;
  int snap_i, snap_w, n;
  logic [11:0] exp_q[$];
  logic [11:0] e;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: monitor at negedge, then return #1 after next posedge.
  task automatic tick();
    @(negedge clk);
    if (rstn) begin
      if (bus.o_mem_rd_en) begin
        chk("rd_addr", 32'(bus.o_mem_rd_addr), 32'(exp_addr));
        chk("rd_under_af", 32'(bus.i_almost_full), 32'd0);
        exp_q.push_back(12'(exp_addr));
        exp_addr++;
        issue_cnt++;
      end
      if (wr_due) begin
        if (bus.i_full) begin
          chk("drop_wr", 32'(bus.o_wr), 32'd0);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          drop_cnt++;
        end else begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hxxx;
          chk("wr", 32'(bus.o_wr), 32'd1);
          chk("wdata", 32'(bus.o_wdata), 32'(e));
          wr_cnt++;
          last_wr_cyc = cyc;
          if (first_wr_cyc < 0) first_wr_cyc = cyc;
        end
      end else begin
        chk("no_wr", 32'(bus.o_wr), 32'd0);
      end
      if (done) begin
        done_cnt++;
        chk("done_gap", 32'(cyc), 32'(last_wr_cyc + 1));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_frame(input logic sel);
    exp_addr     = sel ? FP : 0;
    exp_q.delete();
    issue_cnt    = 0;
    wr_cnt       = 0;
    drop_cnt     = 0;
    done_cnt     = 0;
    first_wr_cyc = -1;
    last_wr_cyc  = -10;
    req     = 1'b1;
    buf_sel = sel;
    t0      = cyc;
    tick();
    req = 1'b0;
  endtask

  task automatic wait_done(input int exp_writes);
    n = 0;
    while (done_cnt == 0 && n < 3 * FP) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done_cnt), 32'd1);
    tick();
    tick();
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("issues", 32'(issue_cnt), 32'(FP));
    chk("writes", 32'(wr_cnt), 32'(exp_writes));
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    rstn = 1'b0;
    req = 1'b0;
    buf_sel = 1'b0;
    bus.i_full = 1'b0;
    bus.i_almost_full = 1'b0;
    exp_addr = 0;
    issue_cnt = 0;
    wr_cnt = 0;
    drop_cnt = 0;
    done_cnt = 0;
    first_wr_cyc = -1;
    last_wr_cyc = -10;
    @(posedge clk);
    #1;
    repeat (4) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rd_en", 32'(bus.o_mem_rd_en), 32'd0);
    chk("rst_addr", 32'(bus.o_mem_rd_addr), 32'd0);
    chk("rst_wr", 32'(bus.o_wr), 32'd0);
    chk("rst_wdata", 32'(bus.o_wdata), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_rerr", 32'(rerr), 32'd0);
    rstn = 1'b1;
    repeat (3) tick();

    // Buffer 0, unstalled: latency and ordering.
    start_frame(1'b0);
    chk("c1_busy", 32'(busy), 32'd1);
    chk("c1_rd_en", 32'(bus.o_mem_rd_en), 32'd1);
    chk("c1_addr", 32'(bus.o_mem_rd_addr), 32'd0);
    wait_done(FP);
    chk("first_wr_lat", 32'(first_wr_cyc - t0), 32'(2 + LAT));
    chk("ovf_clean", 32'(ovf), 32'd0);

    // Buffer 1, select toggled mid-frame.
    start_frame(1'b1);
    chk("b1_first_addr", 32'(bus.o_mem_rd_addr), 32'(FP));
    repeat (300) tick();
    buf_sel = 1'b0;
    repeat (300) tick();
    buf_sel = 1'b1;
    wait_done(FP);
    chk("b1_end_addr", 32'(exp_addr), 32'(2 * FP));

    // Almost-full stall for 50 cycles.
    start_frame(1'b0);
    repeat (500) tick();
    snap_i = issue_cnt;
    snap_w = wr_cnt;
    bus.i_almost_full = 1'b1;
    repeat (50) tick();
    chk("stall_no_rd", 32'(issue_cnt), 32'(snap_i));
    chk("stall_wr_bound", 32'((wr_cnt - snap_w) <= LAT + 1), 32'd1);
    bus.i_almost_full = 1'b0;
    wait_done(FP);

    // Second request mid-frame.
    start_frame(1'b0);
    n = 0;
    while (issue_cnt < 1000 && n < 2 * FP) begin
      tick();
      n++;
    end
    req = 1'b1;
    tick();
    req = 1'b0;
    chk("req_err", 32'(rerr), 32'd1);
    wait_done(FP);

    // FIFO full with returns in flight: 5 pixels dropped.
    start_frame(1'b0);
    repeat (700) tick();
    bus.i_full = 1'b1;
    repeat (5) tick();
    bus.i_full = 1'b0;
    tick();
    chk("ovf_set", 32'(ovf), 32'd1);
    wait_done(FP - 5);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    chk("rerr_sticky", 32'(rerr), 32'd1);

    // Reset mid-FETCH with stale returns.
    start_frame(1'b1);
    repeat (500) tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_rd_en", 32'(bus.o_mem_rd_en), 32'd0);
    chk("ar_addr", 32'(bus.o_mem_rd_addr), 32'd0);
    chk("ar_wdata", 32'(bus.o_wdata), 32'd0);
    chk("ar_ovf", 32'(ovf), 32'd0);
    chk("ar_rerr", 32'(rerr), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    exp_q.delete();
    repeat (4) tick();
    start_frame(1'b0);
    chk("ar_new_addr", 32'(bus.o_mem_rd_addr), 32'd0);
    wait_done(FP);
    chk("ar_ovf_end", 32'(ovf), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
